// File: rtl/liteeth_sram_pkg.sv
// Shared geometry, types and pointer-wrap helper for the LiteEth packet-buffer SRAM
// (liteeth_1rw1r_32w384d_32_sram) and its stream FIFO controller.
package liteeth_sram_pkg;

  localparam int unsigned LITEETH_SRAM_BITS  = 32;
  localparam int unsigned LITEETH_SRAM_DEPTH = 384;
  localparam int unsigned LITEETH_SRAM_AW    = 9;

  typedef logic [LITEETH_SRAM_AW-1:0]   sram_addr_t;
  typedef logic [LITEETH_SRAM_BITS-1:0] sram_word_t;
  // One extra bit so a count can reach DEPTH (and DEPTH+2 for total level).
  typedef logic [LITEETH_SRAM_AW:0]     sram_cnt_t;

  localparam sram_addr_t LastAddr = sram_addr_t'(LITEETH_SRAM_DEPTH - 1);
  localparam sram_cnt_t  DepthCnt = sram_cnt_t'(LITEETH_SRAM_DEPTH);

  // DEPTH is not a power of two, so the wrap is explicit.
  function automatic sram_addr_t next_ptr(sram_addr_t p);
    return (p == LastAddr) ? '0 : p + sram_addr_t'(1);
  endfunction

endpackage

// File: rtl/liteeth_sram_fifo_obuf.sv
// Two-entry output register buffer behind the SRAM read port; entry 0 is always the head,
// so the egress word stays put while the consumer stalls.
module liteeth_sram_fifo_obuf
  import liteeth_sram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       push_i,
  input  sram_word_t push_data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output sram_word_t data_o,
  output logic [1:0] cnt_o
);

  sram_word_t ent_q [2];
  sram_word_t ent_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = ent_q[0];
  assign cnt_o   = cnt_q;
  assign pop     = valid_o && ready_i;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      ent_d[0] = '0;
      ent_d[1] = '0;
      cnt_d    = 2'd0;
    end else begin
      case ({push_i, pop})
        2'b10: begin
          ent_d[cnt_q[0]] = push_data_i;
          cnt_d           = cnt_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          cnt_d    = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent_d[0] = push_data_i;
          end else begin
            ent_d[0] = ent_q[1];
            ent_d[1] = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Stream FIFO controller owning both ports of the LiteEth packet-buffer SRAM.
// Define LITEETH_SRAM_FIFO_LEVEL_EN to add the registered level_o occupancy port.
module liteeth_sram_fifo_ctrl
  import liteeth_sram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       sink_valid_i,
  output logic       sink_ready_o,
  input  sram_word_t sink_data_i,
  output logic       source_valid_o,
  input  logic       source_ready_i,
  output sram_word_t source_data_o,
  output logic       sram_ce_rw1_o,
  output logic       sram_we_rw1_o,
  output sram_word_t sram_w_mask_rw1_o,
  output sram_addr_t sram_addr_rw1_o,
  output sram_word_t sram_wd_rw1_o,
  output logic       sram_ce_r1_o,
  output sram_addr_t sram_addr_r1_o,
  input  sram_word_t sram_rd_r1_i
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  ,
  output sram_cnt_t  level_o
`endif
);

  sram_addr_t wp_q, wp_d;
  sram_addr_t rp_q, rp_d;
  sram_cnt_t  mem_cnt_q, mem_cnt_d;
  logic       rd_inflight_q, rd_inflight_d;
  logic [1:0] obuf_cnt;
  logic [2:0] occ;
  logic       wr_en, pop, issue;

  assign sink_ready_o = (mem_cnt_q != DepthCnt) && !flush_i;
  assign wr_en        = sink_valid_i && sink_ready_o;
  assign pop          = source_valid_o && source_ready_i;

  // Words that will sit in the buffer after this edge without a new issue.
  assign occ   = {1'b0, obuf_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
  assign issue = !flush_i && (mem_cnt_q != '0) && (occ < 3'd2);

  assign sram_w_mask_rw1_o = '1;

  always_comb begin
    sram_ce_rw1_o   = wr_en;
    sram_we_rw1_o   = wr_en;
    sram_addr_rw1_o = wr_en ? wp_q : '0;
    sram_wd_rw1_o   = wr_en ? sink_data_i : '0;
    sram_ce_r1_o    = issue;
    sram_addr_r1_o  = issue ? rp_q : '0;
  end

  always_comb begin
    wp_d          = wp_q;
    rp_d          = rp_q;
    mem_cnt_d     = mem_cnt_q;
    rd_inflight_d = issue;
    if (flush_i) begin
      wp_d          = '0;
      rp_d          = '0;
      mem_cnt_d     = '0;
      rd_inflight_d = 1'b0;
    end else begin
      if (wr_en) wp_d = next_ptr(wp_q);
      if (issue) rp_d = next_ptr(rp_q);
      mem_cnt_d = mem_cnt_q + sram_cnt_t'(wr_en) - sram_cnt_t'(issue);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q          <= '0;
      rp_q          <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Read data arrives the cycle after issue; a flush drops it via clr_i.
  liteeth_sram_fifo_obuf u_obuf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (flush_i),
    .push_i      (rd_inflight_q),
    .push_data_i (sram_rd_r1_i),
    .ready_i     (source_ready_i),
    .valid_o     (source_valid_o),
    .data_o      (source_data_o),
    .cnt_o       (obuf_cnt)
  );

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  sram_cnt_t level_q;

  // Total occupancy only moves on sink accept and source pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else if (flush_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + sram_cnt_t'(wr_en) - sram_cnt_t'(pop);
    end
  end

  assign level_o = level_q;
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Randomized bench for liteeth_sram_fifo_ctrl against a queue-based behavioural model.
module tb_liteeth_sram_fifo_ctrl;
  import liteeth_sram_pkg::*;

  localparam int Depth = 384;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic       sink_valid_i = 1'b0;
  logic       source_ready_i = 1'b0;
  sram_word_t sink_data_i = '0;
  logic       sink_ready_o, source_valid_o;
  sram_word_t source_data_o, sram_w_mask_rw1_o, sram_wd_rw1_o, sram_rd_r1_i;
  logic       sram_ce_rw1_o, sram_we_rw1_o, sram_ce_r1_o;
  sram_addr_t sram_addr_rw1_o, sram_addr_r1_o;
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  sram_cnt_t  level_o;
`endif

  always #5 clk_i = ~clk_i;

  liteeth_sram_fifo_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .sink_valid_i      (sink_valid_i),
    .sink_ready_o      (sink_ready_o),
    .sink_data_i       (sink_data_i),
    .source_valid_o    (source_valid_o),
    .source_ready_i    (source_ready_i),
    .source_data_o     (source_data_o),
    .sram_ce_rw1_o     (sram_ce_rw1_o),
    .sram_we_rw1_o     (sram_we_rw1_o),
    .sram_w_mask_rw1_o (sram_w_mask_rw1_o),
    .sram_addr_rw1_o   (sram_addr_rw1_o),
    .sram_wd_rw1_o     (sram_wd_rw1_o),
    .sram_ce_r1_o      (sram_ce_r1_o),
    .sram_addr_r1_o    (sram_addr_r1_o),
    .sram_rd_r1_i      (sram_rd_r1_i)
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    ,
    .level_o           (level_o)
`endif
  );

  // SRAM macro model; read data is garbage unless a read was issued last cycle.
  sram_word_t sram_mem [Depth];
  sram_word_t rd_q = '0;
  assign sram_rd_r1_i = rd_q;
  always @(posedge clk_i) begin
    if (sram_ce_rw1_o && sram_we_rw1_o) sram_mem[sram_addr_rw1_o] <= sram_wd_rw1_o;
    if (sram_ce_r1_o) rd_q <= sram_mem[sram_addr_r1_o];
    else rd_q <= $urandom;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: SRAM-resident words, one in-flight read, output buffer.
  sram_word_t mq[$];
  sram_word_t oq[$];
  int         wp_m = 0;
  bit         infl_m = 0;
  sram_word_t infl_d_m = '0;
  int         level_m = 0;

  // Observation logs used by the directed literal checks.
  sram_word_t out_log[$];
  sram_word_t in_log[$];
  int acc_cnt, reads, first_acc, first_val, first_pop, last_pop;
  int cyc = 0;
  bit prev_stall = 0;
  sram_word_t prev_data = '0;
  bit e_sr, e_sv, wr, pop, iss;
  int occ, rp_m;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mq.delete(); oq.delete();
      wp_m = 0; infl_m = 0; level_m = 0; prev_stall = 0;
      chk("rst_source_valid", 64'(source_valid_o), 64'(0));
      chk("rst_ce_r1", 64'(sram_ce_r1_o), 64'(0));
    end else begin
      e_sr = (mq.size() != Depth) && !flush_i;
      e_sv = (oq.size() != 0);
      wr   = sink_valid_i && e_sr;
      pop  = e_sv && source_ready_i;
      occ  = oq.size() + int'(infl_m) - int'(pop);
      iss  = !flush_i && (mq.size() != 0) && (occ < 2);
      rp_m = (wp_m - mq.size() + Depth) % Depth;

      chk("sink_ready", 64'(sink_ready_o), 64'(e_sr));
      chk("source_valid", 64'(source_valid_o), 64'(e_sv));
      if (e_sv) chk("source_data", 64'(source_data_o), 64'(oq[0]));
      if (prev_stall) chk("stall_hold", 64'(source_data_o), 64'(prev_data));
      chk("ce_rw1", 64'(sram_ce_rw1_o), 64'(wr));
      chk("we_rw1", 64'(sram_we_rw1_o), 64'(wr));
      chk("addr_rw1", 64'(sram_addr_rw1_o), wr ? 64'(wp_m) : 64'(0));
      chk("wd_rw1", 64'(sram_wd_rw1_o), wr ? 64'(sink_data_i) : 64'(0));
      chk("w_mask", 64'(sram_w_mask_rw1_o), 64'(32'hFFFF_FFFF));
      chk("ce_r1", 64'(sram_ce_r1_o), 64'(iss));
      chk("addr_r1", 64'(sram_addr_r1_o), iss ? 64'(rp_m) : 64'(0));
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
      chk("level", 64'(level_o), 64'(level_m));
`endif

      if (wr) begin
        acc_cnt++;
        in_log.push_back(sink_data_i);
        if (first_acc < 0) first_acc = cyc;
      end
      if (e_sv && first_val < 0) first_val = cyc;
      if (pop) begin
        out_log.push_back(oq[0]);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (iss) reads++;
      prev_stall = e_sv && !source_ready_i && !flush_i;
      prev_data  = source_data_o;

      if (flush_i) begin
        mq.delete(); oq.delete();
        wp_m = 0; infl_m = 0; level_m = 0;
      end else begin
        if (pop) void'(oq.pop_front());
        if (infl_m) oq.push_back(infl_d_m);
        infl_m = iss;
        if (iss) infl_d_m = mq.pop_front();
        if (wr) begin
          mq.push_back(sink_data_i);
          wp_m = (wp_m + 1) % Depth;
        end
        level_m = mq.size() + int'(infl_m) + oq.size();
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_logs();
    out_log.delete(); in_log.delete();
    acc_cnt = 0; reads = 0;
    first_acc = -1; first_val = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    source_ready_i = 1'b1;
    while ((mq.size() != 0 || infl_m || oq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: drain timeout, got %0d words left expected 0", name,
               mq.size() + oq.size());
    end
  endtask

  initial begin
    int bad;
    int budget;
    clear_logs();

    // Reset state.
    #12;
    chk("reset_sink_ready", 64'(sink_ready_o), 64'(1));
    chk("reset_source_valid", 64'(source_valid_o), 64'(0));
    chk("reset_ce_rw1", 64'(sram_ce_rw1_o), 64'(0));
    chk("reset_ce_r1", 64'(sram_ce_r1_o), 64'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Three words, latency and read count.
    clear_logs();
    source_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sink_valid_i = 1'b1;
      sink_data_i  = sram_word_t'(i);
      step();
    end
    sink_valid_i = 1'b0;
    wait_drain(20, "t1_drain");
    // Accept edge follows the accept cycle; valid appears two edges after that.
    chk("t1_latency", 64'(first_val - first_acc), 64'(3));
    chk("t1_count", 64'(out_log.size()), 64'(3));
    for (int i = 0; i < 3; i++) chk("t1_data", 64'(out_log[i]), 64'(i + 1));
    chk("t1_reads", 64'(reads), 64'(3));

    // Fill to capacity DEPTH+2 with the consumer stalled.
    clear_logs();
    source_ready_i = 1'b0;
    for (int i = 0; i < 390; i++) begin
      sink_valid_i = 1'b1;
      sink_data_i  = 32'h0000_1000 + sram_word_t'(i);
      step();
    end
    sink_valid_i = 1'b0;
    chk("t2_accepted", 64'(acc_cnt), 64'(386));
    @(negedge clk_i);
    chk("t2_full_ready", 64'(sink_ready_o), 64'(0));
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    chk("t2_level", 64'(level_o), 64'(386));
`endif
    step();
    wait_drain(500, "t2_drain");
    chk("t2_out_count", 64'(out_log.size()), 64'(386));
    chk("t2_out_last", 64'(out_log[385]), 64'(32'h0000_1000 + 385));

    // Wrap-around streaming at full rate.
    clear_logs();
    source_ready_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      sink_valid_i = 1'b1;
      sink_data_i  = 32'h2000_0000 + sram_word_t'(i);
      step();
    end
    sink_valid_i = 1'b0;
    wait_drain(50, "t3_drain");
    chk("t3_count", 64'(out_log.size()), 64'(1000));
    bad = 0;
    foreach (out_log[i]) if (out_log[i] != 32'h2000_0000 + sram_word_t'(i)) bad++;
    chk("t3_order", 64'(bad), 64'(0));
    chk("t3_no_bubble", 64'(last_pop - first_pop), 64'(999));

    // Random backpressure.
    clear_logs();
    budget = 0;
    while (acc_cnt < 2000 && budget < 20000) begin
      sink_valid_i   = ($urandom_range(0, 3) != 0);
      sink_data_i    = $urandom;
      source_ready_i = $urandom_range(0, 1) != 0;
      step();
      budget++;
    end
    sink_valid_i = 1'b0;
    wait_drain(500, "t4_drain");
    chk("t4_in_count", 64'(in_log.size()), 64'(2000));
    chk("t4_out_count", 64'(out_log.size()), 64'(in_log.size()));
    bad = 0;
    foreach (out_log[i]) if (i < in_log.size() && out_log[i] != in_log[i]) bad++;
    chk("t4_order", 64'(bad), 64'(0));

    // Flush with ten words stored and a read in flight.
    source_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sink_valid_i = 1'b1;
      sink_data_i  = 32'h3000_0000 + sram_word_t'(i);
      step();
    end
    sink_valid_i = 1'b0;
    repeat (3) step();
    source_ready_i = 1'b1;
    step();
    chk("t5_inflight_before_flush", 64'(infl_m), 64'(1));
    source_ready_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    clear_logs();
    @(negedge clk_i);
    chk("t5_valid_after_flush", 64'(source_valid_o), 64'(0));
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    chk("t5_level_after_flush", 64'(level_o), 64'(0));
`endif
    step();
    sink_valid_i   = 1'b1;
    sink_data_i    = 32'hDEAD_BEEF;
    source_ready_i = 1'b1;
    step();
    sink_valid_i = 1'b0;
    repeat (4) step();
    chk("t5_count", 64'(out_log.size()), 64'(1));
    if (out_log.size() > 0) chk("t5_first", 64'(out_log[0]), 64'(32'hDEAD_BEEF));

    // Asynchronous reset mid-stream.
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      sink_valid_i   = 1'b1;
      sink_data_i    = $urandom;
      source_ready_i = $urandom_range(0, 1) != 0;
      step();
    end
    sink_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(source_valid_o), 64'(0));
    chk("t6_rst_ce_rw1", 64'(sram_ce_rw1_o), 64'(0));
    chk("t6_rst_ce_r1", 64'(sram_ce_r1_o), 64'(0));
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    chk("t6_rst_level", 64'(level_o), 64'(0));
`endif
    step();
    step();
    rst_ni = 1'b1;
    clear_logs();
    sink_valid_i   = 1'b1;
    sink_data_i    = 32'hA5A5_A5A5;
    source_ready_i = 1'b1;
    step();
    sink_valid_i = 1'b0;
    repeat (6) step();
    chk("t6_count", 64'(out_log.size()), 64'(1));
    if (out_log.size() > 0) chk("t6_word", 64'(out_log[0]), 64'(32'hA5A5_A5A5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
